// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style interrupt scheduler.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned LVL_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAck1
  } pic_state_e;

  typedef enum logic [1:0] {
    IntaNone   = 2'd0,
    IntaFirst  = 2'd1,
    IntaSecond = 2'd2
  } inta_count_e;

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority resolver: picks the highest-priority request and checks it against
// the highest in-service level under the current priority base.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req_i,
  input  logic [NUM_IR-1:0] isr_i,
  input  logic [LVL_W-1:0]  pb_i,
  output logic [LVL_W-1:0]  cand_level_o,
  output logic              cand_valid_o,
  output logic [LVL_W-1:0]  isr_level_o,
  output logic              isr_any_o
);

  logic [NUM_IR-1:0] req_rot, isr_rot;
  logic [LVL_W-1:0]  req_idx, isr_idx;

  // Rotated bit j holds level pb+j, so bit 0 is the highest priority.
  always_comb begin
    req_rot = '0;
    isr_rot = '0;
    for (int j = 0; j < NUM_IR; j++) begin
      req_rot[j] = req_i[LVL_W'(LVL_W'(j) + pb_i)];
      isr_rot[j] = isr_i[LVL_W'(LVL_W'(j) + pb_i)];
    end
  end

  always_comb begin
    req_idx = '0;
    isr_idx = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (req_rot[i]) req_idx = LVL_W'(i);
      if (isr_rot[i]) isr_idx = LVL_W'(i);
    end
  end

  assign isr_any_o    = |isr_i;
  assign cand_valid_o = (|req_i) && (!isr_any_o || (req_idx < isr_idx));
  assign cand_level_o = req_idx + pb_i;
  assign isr_level_o  = isr_idx + pb_i;

endmodule

// File: rtl/pic_priority_scheduler.sv
// 8259-style interrupt scheduler: IR capture, fully nested / rotating priority,
// two-pulse INTA sequencing and EOI retirement.
module pic_priority_scheduler
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SPURIOUS_LEVEL = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_IR-1:0] IR,
  input  logic              LEVEL,
  input  logic [NUM_IR-1:0] interrupt_mask,
  input  logic              R,
  input  logic              AEOI,
  input  logic              INIT,
  input  logic              INTA_ACK,
  input  logic              EOI_CMD,
  input  logic              EOI_SPECIFIC,
  input  logic [LVL_W-1:0]  EOI_LEVEL,
  output logic              INTERNAL_INT,
  output logic [LVL_W-1:0]  IR_NUM,
  output logic [NUM_IR-1:0] IRR,
  output logic [NUM_IR-1:0] ISR,
  output logic [1:0]        INTA_COUNT
);

  localparam logic [LVL_W-1:0] SpurLvl = LVL_W'(SPURIOUS_LEVEL);

  logic [SYNC_STAGES-1:0][NUM_IR-1:0] sync_q, sync_d;
  logic [NUM_IR-1:0] prev_q, prev_d, irr_q, irr_d, isr_q, isr_d;
  logic [LVL_W-1:0]  pb_q, pb_d, ir_num_q, ir_num_d;
  logic              int_q, int_d;
  inta_count_e       cnt_q, cnt_d;
  pic_state_e        state_q, state_d;

  logic [NUM_IR-1:0] synced, isr_eoi;
  logic [LVL_W-1:0]  pb_eoi, isr_top, cand_level;
  logic              isr_any, cand_valid;
  logic [LVL_W-1:0]  unused_cand_lvl, unused_isr_lvl;
  logic              unused_cand_vld, unused_isr_any;

  assign synced = sync_q[SYNC_STAGES-1];

  pic_priority_resolver u_eoi_res (
    .req_i        ('0),
    .isr_i        (isr_q),
    .pb_i         (pb_q),
    .cand_level_o (unused_cand_lvl),
    .cand_valid_o (unused_cand_vld),
    .isr_level_o  (isr_top),
    .isr_any_o    (isr_any)
  );

  // Candidate is judged against the ISR and priority base after any same-cycle EOI.
  pic_priority_resolver u_cand_res (
    .req_i        (irr_q & ~interrupt_mask),
    .isr_i        (isr_eoi),
    .pb_i         (pb_eoi),
    .cand_level_o (cand_level),
    .cand_valid_o (cand_valid),
    .isr_level_o  (unused_isr_lvl),
    .isr_any_o    (unused_isr_any)
  );

  always_comb begin
    isr_eoi = isr_q;
    pb_eoi  = pb_q;
    if (EOI_CMD) begin
      if (EOI_SPECIFIC) begin
        if (isr_q[EOI_LEVEL]) begin
          isr_eoi[EOI_LEVEL] = 1'b0;
          if (R) pb_eoi = EOI_LEVEL + 3'd1;
        end
      end else if (isr_any) begin
        isr_eoi[isr_top] = 1'b0;
        if (R) pb_eoi = isr_top + 3'd1;
      end
    end
  end

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], IR};
    prev_d   = synced;
    irr_d    = LEVEL ? synced : (irr_q | (synced & ~prev_q));
    isr_d    = isr_eoi;
    pb_d     = pb_eoi;
    ir_num_d = ir_num_q;
    int_d    = int_q;
    cnt_d    = cnt_q;
    state_d  = state_q;

    unique case (state_q)
      StIdle: begin
        if (cand_valid) begin
          state_d = StReq;
          int_d   = 1'b1;
          cnt_d   = IntaNone;
        end
      end
      StReq: begin
        if (INTA_ACK) begin
          state_d = StAck1;
          cnt_d   = IntaFirst;
          if (cand_valid) begin
            ir_num_d          = cand_level;
            isr_d[cand_level] = 1'b1;
            irr_d[cand_level] = 1'b0;
          end else begin
            ir_num_d = SpurLvl;
          end
        end
      end
      StAck1: begin
        if (INTA_ACK) begin
          state_d = StIdle;
          cnt_d   = IntaSecond;
          int_d   = 1'b0;
          if (AEOI) begin
            isr_d[ir_num_q] = 1'b0;
            if (R) pb_d = ir_num_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (INIT) begin
      sync_d   = '0;
      prev_d   = '0;
      irr_d    = '0;
      isr_d    = '0;
      pb_d     = '0;
      ir_num_d = '0;
      int_d    = 1'b0;
      cnt_d    = IntaNone;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q   <= '0;
      prev_q   <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      pb_q     <= '0;
      ir_num_q <= '0;
      int_q    <= 1'b0;
      cnt_q    <= IntaNone;
      state_q  <= StIdle;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      pb_q     <= pb_d;
      ir_num_q <= ir_num_d;
      int_q    <= int_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  assign INTERNAL_INT = int_q;
  assign IR_NUM       = ir_num_q;
  assign IRR          = irr_q;
  assign ISR          = isr_q;
  assign INTA_COUNT   = cnt_q;

endmodule
